// File: rtl/msdap_out_pkg.sv
// Shared types and constants for the MSDAP output staging block.
// Feature macro: OUT_HOLD_LAST_EN (see msdap_out_stage.sv).
package msdap_out_pkg;

   // Default width of one channel result word.
   localparam int DATA_W_DEF = 40;

   // Output sequencing states.
   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      ARMED   = 2'd1,
      LOAD_ST = 2'd2,
      SHIFT   = 2'd3
   } out_state_t;

   // One left/right result pair as held in the staging FIFO.
   typedef struct packed {
      logic [DATA_W_DEF-1:0] L;
      logic [DATA_W_DEF-1:0] R;
   } pair_t;

endpackage

// File: rtl/msdap_pair_fifo.sv
// Small synchronous FIFO of L/R pairs. The pointers and occupancy are cleared
// by CLR. The storage array itself is not reset, so it can map onto RAM.
// The head entry is presented continuously on rd_data.
module msdap_pair_fifo
   import msdap_out_pkg::*;
#(
   parameter int DEPTH = 2,
   localparam int AW   = $clog2(DEPTH)
) (
   input  logic          SCLK,
   input  logic          CLR,
   input  logic          push,
   input  logic          pop,
   input  pair_t         wr_data,
   output pair_t         rd_data,
   output logic          full,
   output logic          empty,
   output logic [AW:0]   count
);

   pair_t          mem [DEPTH];
   logic [AW-1:0]  wr_ptr_reg;
   logic [AW-1:0]  rd_ptr_reg;
   logic [AW:0]    count_reg;
   logic           push_ok;
   logic           pop_ok;

   assign full    = (count_reg == (AW+1)'(DEPTH));
   assign empty   = (count_reg == '0);
   assign count   = count_reg;
   assign push_ok = push & ~full;
   assign pop_ok  = pop & ~empty;
   assign rd_data = mem[rd_ptr_reg];

   // Storage write; the array is not reset.
   always_ff @(posedge SCLK) begin
      if (push_ok)
         mem[wr_ptr_reg] <= wr_data;
   end

   // Pointer and occupancy bookkeeping. The pointers wrap naturally at DEPTH.
   always_ff @(posedge SCLK or posedge CLR) begin
      if (CLR) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         count_reg  <= '0;
      end else begin
         if (push_ok)
            wr_ptr_reg <= wr_ptr_reg + 1'b1;
         if (pop_ok)
            rd_ptr_reg <= rd_ptr_reg + 1'b1;
         case ({push_ok, pop_ok})
            2'b10:   count_reg <= count_reg + 1'b1;
            2'b01:   count_reg <= count_reg - 1'b1;
            default: count_reg <= count_reg;
         endcase
      end
   end

endmodule

// File: rtl/msdap_out_stage.sv
// MSDAP output staging: buffers L/R result pairs and issues one LOAD per frame
// to the parallel-to-serial shifters. UNDERRUN and SLIP are sticky flags.
// Feature macro: OUT_HOLD_LAST_EN. When it is defined, an underrun keeps the
// previously sent pair on PDATA instead of sending zeros.
// DATA_W must equal DATA_W_DEF, because the FIFO stores pair_t.
module msdap_out_stage
   import msdap_out_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF,
   parameter int DEPTH  = 2
) (
   input  logic              SCLK,
   input  logic              CLR,
   input  logic              FRAME,
   input  logic              RES_VALID,
   output logic              RES_READY,
   input  logic [DATA_W-1:0] RES_L,
   input  logic [DATA_W-1:0] RES_R,
   input  logic              P2S_BUSY,
   output logic              LOAD,
   output logic [DATA_W-1:0] PDATA_L,
   output logic [DATA_W-1:0] PDATA_R,
   output logic              UNDERRUN,
   output logic              SLIP
);

   localparam int AW = $clog2(DEPTH);

   out_state_t        state_reg;
   logic              frame_d_reg;
   logic              busy_seen_reg;
   logic              wait_cnt_reg;
   logic              load_reg;
   logic              underrun_reg;
   logic              slip_reg;
   logic [DATA_W-1:0] pdata_l_reg;
   logic [DATA_W-1:0] pdata_r_reg;

   logic              fs;
   logic              push;
   logic              pop;
   logic              armed_fs;
   pair_t             wr_pair;
   pair_t             head_pair;
   logic              fifo_full;
   logic              fifo_empty;
   logic [AW:0]       fifo_count;

   // READY comes only from the registered occupancy, never from RES_VALID.
   assign RES_READY = (fifo_count != (AW+1)'(DEPTH));
   assign push      = RES_VALID & ~fifo_full;
   assign fs        = FRAME & ~frame_d_reg;
   assign armed_fs  = (state_reg == ARMED) & fs;
   assign pop       = armed_fs & ~fifo_empty;
   assign wr_pair.L = RES_L;
   assign wr_pair.R = RES_R;

   assign LOAD     = load_reg;
   assign PDATA_L  = pdata_l_reg;
   assign PDATA_R  = pdata_r_reg;
   assign UNDERRUN = underrun_reg;
   assign SLIP     = slip_reg;

   msdap_pair_fifo #(.DEPTH(DEPTH)) u_fifo (
      .SCLK    (SCLK),
      .CLR     (CLR),
      .push    (push),
      .pop     (pop),
      .wr_data (wr_pair),
      .rd_data (head_pair),
      .full    (fifo_full),
      .empty   (fifo_empty),
      .count   (fifo_count)
   );

   // Delay FRAME by one cycle so that a rising edge can be detected.
   always_ff @(posedge SCLK or posedge CLR) begin
      if (CLR) frame_d_reg <= 1'b0;
      else     frame_d_reg <= FRAME;
   end

   // Frame sequencer. In SHIFT, wait for the busy pulse; give up after two quiet cycles.
   always_ff @(posedge SCLK or posedge CLR) begin
      if (CLR) begin
         state_reg     <= IDLE;
         busy_seen_reg <= 1'b0;
         wait_cnt_reg  <= 1'b0;
      end else begin
         case (state_reg)
            IDLE:    if (push) state_reg <= ARMED;
            ARMED:   if (fs) state_reg <= LOAD_ST;
            LOAD_ST: begin
               state_reg     <= SHIFT;
               busy_seen_reg <= 1'b0;
               wait_cnt_reg  <= 1'b0;
            end
            SHIFT: begin
               wait_cnt_reg <= 1'b1;
               if (P2S_BUSY)
                  busy_seen_reg <= 1'b1;
               else if (busy_seen_reg || wait_cnt_reg)
                  state_reg <= ARMED;
            end
            default: state_reg <= IDLE;
         endcase
      end
   end

   // LOAD is high for the single cycle after the edge that accepted fs.
   always_ff @(posedge SCLK or posedge CLR) begin
      if (CLR) load_reg <= 1'b0;
      else     load_reg <= armed_fs;
   end

   // Capture the FIFO head at an accepted frame start, or apply the underrun policy.
   always_ff @(posedge SCLK or posedge CLR) begin
      if (CLR) begin
         pdata_l_reg <= '0;
         pdata_r_reg <= '0;
      end else if (armed_fs) begin
         if (!fifo_empty) begin
            pdata_l_reg <= head_pair.L;
            pdata_r_reg <= head_pair.R;
         end else begin
`ifdef OUT_HOLD_LAST_EN
            pdata_l_reg <= pdata_l_reg;
            pdata_r_reg <= pdata_r_reg;
`else
            pdata_l_reg <= '0;
            pdata_r_reg <= '0;
`endif
         end
      end
   end

   // Sticky flags: an underrun at an accepted frame start, or a frame start dropped mid-transfer.
   always_ff @(posedge SCLK or posedge CLR) begin
      if (CLR) begin
         underrun_reg <= 1'b0;
         slip_reg     <= 1'b0;
      end else begin
         if (armed_fs && fifo_empty)
            underrun_reg <= 1'b1;
         if (fs && (state_reg == LOAD_ST || state_reg == SHIFT))
            slip_reg <= 1'b1;
      end
   end

endmodule

// File: tb/tb_msdap_out_stage.sv
// Directed testbench for msdap_out_stage. Expected values are hand-computed.
// Inputs change 1 ns after each rising edge, and outputs are checked at the same point.
module tb_msdap_out_stage;

   logic        SCLK = 1'b0;
   logic        CLR = 1'b1;
   logic        FRAME = 1'b0;
   logic        RES_VALID = 1'b0;
   logic        RES_READY;
   logic [39:0] RES_L = '0;
   logic [39:0] RES_R = '0;
   logic        P2S_BUSY = 1'b0;
   logic        LOAD;
   logic [39:0] PDATA_L;
   logic [39:0] PDATA_R;
   logic        UNDERRUN;
   logic        SLIP;

   int checks = 0;
   int failures = 0;

   msdap_out_stage #(.DATA_W(40), .DEPTH(2)) dut (
      .SCLK      (SCLK),
      .CLR       (CLR),
      .FRAME     (FRAME),
      .RES_VALID (RES_VALID),
      .RES_READY (RES_READY),
      .RES_L     (RES_L),
      .RES_R     (RES_R),
      .P2S_BUSY  (P2S_BUSY),
      .LOAD      (LOAD),
      .PDATA_L   (PDATA_L),
      .PDATA_R   (PDATA_R),
      .UNDERRUN  (UNDERRUN),
      .SLIP      (SLIP)
   );

   always #5 SCLK = ~SCLK;

   task automatic check_val(input string tag, input logic [39:0] got, input logic [39:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end else begin
         $display("ok   %s = %h", tag, got);
      end
   endtask

   task automatic tick;
      @(posedge SCLK);
      #1;
   endtask

   task automatic push_pair(input string tag, input logic [39:0] l, input logic [39:0] r);
      RES_L = l;
      RES_R = r;
      RES_VALID = 1'b1;
      check_val({tag, "_ready"}, 40'(RES_READY), 40'd1);
      tick;
      RES_VALID = 1'b0;
   endtask

   task automatic frame_edge;
      FRAME = 1'b1;
      tick;
      FRAME = 1'b0;
   endtask

   task automatic expect_load(input string tag, input logic [39:0] l, input logic [39:0] r);
      check_val({tag, "_load"}, 40'(LOAD), 40'd1);
      check_val({tag, "_pdl"}, PDATA_L, l);
      check_val({tag, "_pdr"}, PDATA_R, r);
   endtask

   task automatic run_busy(input int n);
      P2S_BUSY = 1'b1;
      repeat (n) tick;
      P2S_BUSY = 1'b0;
      tick;
   endtask

   task automatic run_shift(input string tag, input int n);
      tick;
      check_val({tag, "_load_off"}, 40'(LOAD), 40'd0);
      run_busy(n);
   endtask

   logic [39:0] exp_l;
   logic [39:0] exp_r;

   initial begin
      repeat (3) @(posedge SCLK);
      #1 CLR = 1'b0;

      // reset state
      check_val("rst_load", 40'(LOAD), 40'd0);
      check_val("rst_pdl", PDATA_L, 40'd0);
      check_val("rst_pdr", PDATA_R, 40'd0);
      check_val("rst_underrun", 40'(UNDERRUN), 40'd0);
      check_val("rst_slip", 40'(SLIP), 40'd0);
      check_val("rst_ready", 40'(RES_READY), 40'd1);

      // a frame edge in IDLE is ignored
      frame_edge;
      check_val("idle_load", 40'(LOAD), 40'd0);
      tick;
      check_val("idle_load2", 40'(LOAD), 40'd0);
      check_val("idle_underrun", 40'(UNDERRUN), 40'd0);

      // basic transfer with extreme word values
      push_pair("b", 40'h00_0000_0001, 40'hFF_FFFF_FFFF);
      frame_edge;
      expect_load("b", 40'h00_0000_0001, 40'hFF_FFFF_FFFF);
      check_val("b_underrun", 40'(UNDERRUN), 40'd0);
      run_shift("b", 3);

      // fill the FIFO, hold off a third pair, and check ordering
      push_pair("c1", 40'h11_1111_1111, 40'h21_2121_2121);
      push_pair("c2", 40'h12_1212_1212, 40'h22_2222_2222);
      check_val("c_full_ready", 40'(RES_READY), 40'd0);
      RES_L = 40'h13_1313_1313;
      RES_R = 40'h23_2323_2323;
      RES_VALID = 1'b1;
      tick;
      check_val("c_held_ready", 40'(RES_READY), 40'd0);
      frame_edge;
      expect_load("c1", 40'h11_1111_1111, 40'h21_2121_2121);
      check_val("c_pop_ready", 40'(RES_READY), 40'd1);
      tick;
      RES_VALID = 1'b0;
      check_val("c3_load_off", 40'(LOAD), 40'd0);
      check_val("c3_ready", 40'(RES_READY), 40'd0);
      run_busy(2);
      frame_edge;
      expect_load("c2", 40'h12_1212_1212, 40'h22_2222_2222);
      run_shift("c2", 2);
      frame_edge;
      expect_load("c3", 40'h13_1313_1313, 40'h23_2323_2323);
      check_val("c_underrun", 40'(UNDERRUN), 40'd0);
      check_val("c_end_ready", 40'(RES_READY), 40'd1);
      run_shift("c3", 2);

      // underrun: FIFO empty in ARMED
`ifdef OUT_HOLD_LAST_EN
      exp_l = 40'h13_1313_1313;
      exp_r = 40'h23_2323_2323;
`else
      exp_l = 40'h0;
      exp_r = 40'h0;
`endif
      frame_edge;
      expect_load("d_un", exp_l, exp_r);
      check_val("d_underrun", 40'(UNDERRUN), 40'd1);
      run_shift("d_un", 2);
      push_pair("d1", 40'h44_4444_4444, 40'h55_5555_5555);
      frame_edge;
      expect_load("d1", 40'h44_4444_4444, 40'h55_5555_5555);
      check_val("d_sticky", 40'(UNDERRUN), 40'd1);
      run_shift("d1", 2);

      // P2S_BUSY never rises: time out back to ARMED
      push_pair("t1", 40'h66_0000_0066, 40'h77_0000_0077);
      frame_edge;
      expect_load("t1", 40'h66_0000_0066, 40'h77_0000_0077);
      repeat (3) tick;
      frame_edge;
      check_val("t_timeout_load", 40'(LOAD), 40'd1);
      check_val("t_slip", 40'(SLIP), 40'd0);
      run_shift("t2", 2);

      // slip: a frame edge during a transfer is dropped without a pop
      push_pair("e1", 40'hE1_0000_00E1, 40'hE1_1111_11E1);
      push_pair("e2", 40'hE2_0000_00E2, 40'hE2_2222_22E2);
      frame_edge;
      expect_load("e1", 40'hE1_0000_00E1, 40'hE1_1111_11E1);
      tick;
      P2S_BUSY = 1'b1;
      repeat (9) tick;
      frame_edge;
      check_val("e_slip", 40'(SLIP), 40'd1);
      check_val("e_slip_load", 40'(LOAD), 40'd0);
      check_val("e_slip_pdl", PDATA_L, 40'hE1_0000_00E1);
      P2S_BUSY = 1'b0;
      tick;
      check_val("e_ready", 40'(RES_READY), 40'd1);
      push_pair("e3", 40'hE3_0000_00E3, 40'hE3_3333_33E3);
      check_val("e_full", 40'(RES_READY), 40'd0);
      frame_edge;
      expect_load("e2", 40'hE2_0000_00E2, 40'hE2_2222_22E2);
      run_shift("e2", 2);
      frame_edge;
      expect_load("e3", 40'hE3_0000_00E3, 40'hE3_3333_33E3);
      run_shift("e3", 2);

      // push and frame start on the same edge with one pair stored
      push_pair("f1", 40'hF1_0000_00F1, 40'hF1_1111_11F1);
      RES_L = 40'hF2_0000_00F2;
      RES_R = 40'hF2_2222_22F2;
      RES_VALID = 1'b1;
      check_val("f_same_ready", 40'(RES_READY), 40'd1);
      frame_edge;
      RES_VALID = 1'b0;
      expect_load("f1", 40'hF1_0000_00F1, 40'hF1_1111_11F1);
      check_val("f_count1_ready", 40'(RES_READY), 40'd1);
      run_shift("f1", 2);
      frame_edge;
      expect_load("f2", 40'hF2_0000_00F2, 40'hF2_2222_22F2);
      run_shift("f2", 2);

      // asynchronous CLR in the middle of SHIFT
      push_pair("g1", 40'h98_7654_3210, 40'h01_2345_6789);
      frame_edge;
      expect_load("g1", 40'h98_7654_3210, 40'h01_2345_6789);
      tick;
      P2S_BUSY = 1'b1;
      tick;
      tick;
      #2 CLR = 1'b1;
      #1;
      check_val("g_clr_load", 40'(LOAD), 40'd0);
      check_val("g_clr_pdl", PDATA_L, 40'd0);
      check_val("g_clr_pdr", PDATA_R, 40'd0);
      check_val("g_clr_underrun", 40'(UNDERRUN), 40'd0);
      check_val("g_clr_slip", 40'(SLIP), 40'd0);
      check_val("g_clr_ready", 40'(RES_READY), 40'd1);
      P2S_BUSY = 1'b0;
      @(posedge SCLK);
      #1 CLR = 1'b0;
      frame_edge;
      check_val("g_idle_load", 40'(LOAD), 40'd0);
      tick;
      check_val("g_idle_load2", 40'(LOAD), 40'd0);
      check_val("g_idle_underrun", 40'(UNDERRUN), 40'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
